upower_d_fetch_decode: RTL and testbench
========================================

UPOWER_D_FETCH_DECODE -- requirements
Module: upower_d_fetch_decode

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 4, byte increment between sequential instructions.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low, released synchronously to clk.
REQ-005 start  input  1  level; while high in IDLE, fetching begins.
REQ-006 imem_req  output  1  fetch request strobe to instruction memory.
REQ-007 imem_addr  output  64  fetch address, equal to PC while imem_req is high.
REQ-008 imem_valid  input  1  instruction word returned, 1+ cycles after accepted request.
REQ-009 imem_rdata  input  32  instruction word, valid with imem_valid.
REQ-010 redirect  input  1  one-cycle pulse; flush and restart fetch at redirect_pc.
REQ-011 redirect_pc  input  64  new PC, sampled when redirect is high.
REQ-012 d_valid  output  1  decoded D-format fields valid for downstream D-format execute stage.
REQ-013 d_ready  input  1  downstream accepts fields on a cycle with d_valid and d_ready both high.
REQ-014 PO  output  6  primary opcode, instr[31:26].
REQ-015 rt  output  5  target register, instr[25:21].
REQ-016 ra  output  5  source register, instr[20:16].
REQ-017 SI  output  48  instr[15:0] sign-extended to 48 bits.
REQ-018 d_pc  output  64  address of the instruction currently presented.
REQ-019 illegal  output  1  sticky; unsupported opcode fetched, block halted.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, WAIT, ISSUE, HALT.
REQ-021 IDLE -> FETCH when start=1; otherwise remain in IDLE.
REQ-022 FETCH SHALL assert imem_req for exactly one cycle with imem_addr=PC, then go to WAIT; one request outstanding at most.
REQ-023 WAIT on imem_valid=1: supported opcode -> register fields, d_pc=PC, PC=PC+PC_STEP, go to ISSUE; unsupported opcode -> illegal=1, d_pc=PC, go to HALT.
REQ-024 Supported opcodes SHALL be 14 (addi), 15 (addis), 24 (ori), 26 (xori), 28 (andi); all others are illegal.
REQ-025 ISSUE SHALL hold d_valid=1 with PO/rt/ra/SI/d_pc stable until the d_ready handshake; on handshake -> FETCH, so sustained throughput is one instruction per 3 cycles with 1-cycle memory.
REQ-026 Outputs PO/rt/ra/SI SHALL come from registers, never combinationally from imem_rdata.
REQ-027 SI sign extension: instr[15]=1 -> SI[47:16] all ones; instr[15]=0 -> all zeros.
REQ-028 PC arithmetic SHALL wrap modulo 2^64 without flag.
REQ-029 redirect in any state except HALT: PC=redirect_pc, d_valid=0 next cycle, next state FETCH; redirect overrides a same-cycle handshake or imem_valid.
REQ-030 imem_valid arriving in WAIT after a redirect-flushed request SHALL be discarded; one stale response per flushed request is dropped.
REQ-031 imem_valid outside WAIT (except stale case) SHALL be ignored.
REQ-032 HALT SHALL be left only by reset; redirect and start ignored; d_valid=0, imem_req=0.
REQ-033 start deasserted after leaving IDLE SHALL have no effect.

Reset
REQ-034 On rst_n=0, immediately: state=IDLE, PC=RESET_PC, d_valid=0, imem_req=0, imem_addr=RESET_PC, PO=0, rt=0, ra=0, SI=0, d_pc=0, illegal=0, stale-drop counter=0.
REQ-035 Reset mid-WAIT SHALL discard the outstanding request; a response after reset release is ignored in IDLE.

Verification
REQ-036 start=1, imem returns 32'h39EC000A (addi r15,r12,10) after 1 cycle, d_ready=1 -> d_valid with PO=14, rt=15, ra=12, SI=48'h00000000000A, d_pc=0; next imem_addr=4.
REQ-037 instr 32'h70E7FFF6 (andi), d_ready=0 for 5 cycles -> PO=28, SI=48'hFFFFFFFFFFF6 held stable, no new imem_req until d_ready=1.
REQ-038 instr PO=31 -> illegal=1, d_pc=fetch address, HALT; later start/redirect produce no imem_req.
REQ-039 redirect with redirect_pc=64'h100 during WAIT, old response arrives next cycle -> response dropped, next imem_req addr 64'h100, first issued d_pc=64'h100.
REQ-040 PC=64'hFFFFFFFFFFFFFFFC, valid ori fetched -> next imem_addr=0.
REQ-041 rst_n pulled low during ISSUE -> d_valid=0 and all outputs at reset values within the same cycle, no clock edge needed.

Source files
------------

// File: rtl/upower_d_fetch_decode.sv
// Fetch/decode front end for D-format immediate instructions.
// Fetches one word at a time from instruction memory, decodes the D-format
// fields into registers and presents them to the execute stage with a
// valid/ready handshake. Redirects flush the in-flight fetch; responses to
// flushed requests are counted and dropped when they eventually return.
module upower_d_fetch_decode #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [5:0]  PO,
    output logic [4:0]  rt,
    output logic [4:0]  ra,
    output logic [47:0] SI,
    output logic [63:0] d_pc,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [63:0] PC_INC = 64'(PC_STEP);

    state_t      state_r;
    logic [63:0] pc_r;
    logic        imem_req_r;
    logic [63:0] imem_addr_r;
    logic        d_valid_r;
    logic [5:0]  po_r;
    logic [4:0]  rt_r;
    logic [4:0]  ra_r;
    logic [47:0] si_r;
    logic [63:0] d_pc_r;
    logic        illegal_r;
    logic [3:0]  stale_cnt_r;

    logic        stale_drop_s;
    logic        stale_inc_s;

    // Only the five D-format immediate opcodes are executable downstream.
    function automatic logic is_supported(input logic [5:0] op);
        case (op)
            6'd14, 6'd15, 6'd24, 6'd26, 6'd28: is_supported = 1'b1;
            default:                           is_supported = 1'b0;
        endcase
    endfunction

    // Sign-extend the 16-bit immediate to the 48-bit SI field.
    function automatic logic [47:0] sext_si(input logic [15:0] imm);
        sext_si = {{32{imm[15]}}, imm};
    endfunction

    // Track responses owed to flushed requests: a request is flushed when a
    // redirect hits while it is being issued or is still outstanding.
    always_comb begin
        stale_drop_s = 1'b0;
        stale_inc_s  = 1'b0;
        if (imem_valid && (stale_cnt_r != 4'd0)) begin
            stale_drop_s = 1'b1;
        end else begin
            stale_drop_s = 1'b0;
        end
        if (redirect && (state_r == FETCH)) begin
            stale_inc_s = 1'b1;
        end else if (redirect && (state_r == WAIT) && !(imem_valid && (stale_cnt_r == 4'd0))) begin
            stale_inc_s = 1'b1;
        end else begin
            stale_inc_s = 1'b0;
        end
    end

    // Outstanding flushed-request counter; in-order memory means stale
    // responses always precede the live one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale_cnt_r <= 4'd0;
        end else begin
            stale_cnt_r <= stale_cnt_r + {3'd0, stale_inc_s} - {3'd0, stale_drop_s};
        end
    end

    // Main control FSM with registered request, field and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC;
            imem_req_r  <= 1'b0;
            imem_addr_r <= RESET_PC;
            d_valid_r   <= 1'b0;
            po_r        <= 6'd0;
            rt_r        <= 5'd0;
            ra_r        <= 5'd0;
            si_r        <= 48'd0;
            d_pc_r      <= 64'd0;
            illegal_r   <= 1'b0;
        end else if (state_r == HALT) begin
            imem_req_r <= 1'b0;
            d_valid_r  <= 1'b0;
        end else if (redirect) begin
            pc_r        <= redirect_pc;
            imem_addr_r <= redirect_pc;
            imem_req_r  <= 1'b1;
            d_valid_r   <= 1'b0;
            state_r     <= FETCH;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= pc_r;
                        state_r     <= FETCH;
                    end
                end
                FETCH: begin
                    imem_req_r <= 1'b0;
                    state_r    <= WAIT;
                end
                WAIT: begin
                    if (imem_valid && !stale_drop_s) begin
                        d_pc_r <= pc_r;
                        if (is_supported(imem_rdata[31:26])) begin
                            po_r      <= imem_rdata[31:26];
                            rt_r      <= imem_rdata[25:21];
                            ra_r      <= imem_rdata[20:16];
                            si_r      <= sext_si(imem_rdata[15:0]);
                            pc_r      <= pc_r + PC_INC;
                            d_valid_r <= 1'b1;
                            state_r   <= ISSUE;
                        end else begin
                            illegal_r <= 1'b1;
                            state_r   <= HALT;
                        end
                    end
                end
                ISSUE: begin
                    if (d_ready) begin
                        d_valid_r   <= 1'b0;
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= pc_r;
                        state_r     <= FETCH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign d_valid   = d_valid_r;
    assign PO        = po_r;
    assign rt        = rt_r;
    assign ra        = ra_r;
    assign SI        = si_r;
    assign d_pc      = d_pc_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_upower_d_fetch_decode.sv
// Directed bench for upower_d_fetch_decode: hand-computed vectors applied
// in one linear sequence, each comparison an immediate assertion.
module tb_upower_d_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        d_valid;
    logic        d_ready;
    logic [5:0]  PO;
    logic [4:0]  rt;
    logic [4:0]  ra;
    logic [47:0] SI;
    logic [63:0] d_pc;
    logic        illegal;

    int compared   = 0;
    int mismatched = 0;

    upower_d_fetch_decode dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .PO          (PO),
        .rt          (rt),
        .ra          (ra),
        .SI          (SI),
        .d_pc        (d_pc),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        imem_valid  = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        d_ready     = 1'b0;
        #12;
        chk("rst_d_valid", {63'd0, d_valid}, 64'd0);
        chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
        chk("rst_imem_addr", imem_addr, 64'h0);
        chk("rst_PO", {58'd0, PO}, 64'd0);
        chk("rst_SI", {16'd0, SI}, 64'd0);
        chk("rst_d_pc", d_pc, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", {63'd0, imem_req}, 64'd0);

        // addi r15,r12,10 with 1-cycle memory
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f1_req", {63'd0, imem_req}, 64'd1);
        chk("f1_addr", imem_addr, 64'h0);
        tick();
        chk("w1_req_low", {63'd0, imem_req}, 64'd0);
        imem_valid = 1'b1;
        imem_rdata = 32'h39EC000A;
        tick();
        imem_valid = 1'b0;
        chk("i1_d_valid", {63'd0, d_valid}, 64'd1);
        chk("i1_PO", {58'd0, PO}, 64'd14);
        chk("i1_rt", {59'd0, rt}, 64'd15);
        chk("i1_ra", {59'd0, ra}, 64'd12);
        chk("i1_SI", {16'd0, SI}, 64'h00000000000A);
        chk("i1_d_pc", d_pc, 64'h0);
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        chk("f2_req", {63'd0, imem_req}, 64'd1);
        chk("f2_addr", imem_addr, 64'h4);
        chk("f2_d_valid", {63'd0, d_valid}, 64'd0);

        // andi with back-pressure for 5 cycles
        tick();
        imem_valid = 1'b1;
        imem_rdata = 32'h70E7FFF6;
        tick();
        imem_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_d_valid", {63'd0, d_valid}, 64'd1);
            chk("bp_PO", {58'd0, PO}, 64'd28);
            chk("bp_SI", {16'd0, SI}, 64'hFFFFFFFFFFF6);
            chk("bp_d_pc", d_pc, 64'h4);
            chk("bp_no_req", {63'd0, imem_req}, 64'd0);
            tick();
        end
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        chk("f3_addr", imem_addr, 64'h8);

        // redirect during WAIT; stale response arrives while waiting for the new fetch
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        tick();
        redirect = 1'b0;
        chk("rd_req", {63'd0, imem_req}, 64'd1);
        chk("rd_addr", imem_addr, 64'h100);
        tick();
        imem_valid = 1'b1;
        imem_rdata = 32'h39EC000A;
        tick();
        chk("stale_dropped", {63'd0, d_valid}, 64'd0);
        imem_rdata = 32'h60648001;
        tick();
        imem_valid = 1'b0;
        chk("rd_d_valid", {63'd0, d_valid}, 64'd1);
        chk("rd_d_pc", d_pc, 64'h100);
        chk("rd_PO", {58'd0, PO}, 64'd24);
        chk("rd_rt", {59'd0, rt}, 64'd3);
        chk("rd_ra", {59'd0, ra}, 64'd4);
        chk("rd_SI", {16'd0, SI}, 64'hFFFFFFFF8001);
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        chk("f4_addr", imem_addr, 64'h104);

        // redirect during FETCH to the top of the address space, then wrap
        redirect    = 1'b1;
        redirect_pc = 64'hFFFFFFFFFFFFFFFC;
        tick();
        redirect = 1'b0;
        chk("wr_addr", imem_addr, 64'hFFFFFFFFFFFFFFFC);
        tick();
        imem_valid = 1'b1;
        imem_rdata = 32'h39EC000A;
        tick();
        chk("wr_stale_dropped", {63'd0, d_valid}, 64'd0);
        imem_rdata = 32'h60648001;
        tick();
        imem_valid = 1'b0;
        chk("wr_d_pc", d_pc, 64'hFFFFFFFFFFFFFFFC);
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        chk("wr_wrap_addr", imem_addr, 64'h0);
        chk("wr_wrap_req", {63'd0, imem_req}, 64'd1);

        // unsupported opcode 31 halts the block
        tick();
        imem_valid = 1'b1;
        imem_rdata = 32'h7C000000;
        tick();
        imem_valid = 1'b0;
        chk("ill_flag", {63'd0, illegal}, 64'd1);
        chk("ill_d_pc", d_pc, 64'h0);
        chk("ill_d_valid", {63'd0, d_valid}, 64'd0);
        start       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_no_req", {63'd0, imem_req}, 64'd0);
            chk("halt_sticky", {63'd0, illegal}, 64'd1);
        end
        start    = 1'b0;
        redirect = 1'b0;

        // reset from HALT, reach ISSUE, then asynchronous reset mid-cycle
        rst_n = 1'b0;
        #2;
        chk("rst2_illegal", {63'd0, illegal}, 64'd0);
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r2_addr", imem_addr, 64'h0);
        tick();
        imem_valid = 1'b1;
        imem_rdata = 32'h39EC000A;
        tick();
        imem_valid = 1'b0;
        chk("r2_d_valid", {63'd0, d_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_d_valid", {63'd0, d_valid}, 64'd0);
        chk("async_PO", {58'd0, PO}, 64'd0);
        chk("async_rt", {59'd0, rt}, 64'd0);
        chk("async_d_pc", d_pc, 64'd0);
        chk("async_imem_addr", imem_addr, 64'h0);
        chk("async_imem_req", {63'd0, imem_req}, 64'd0);
        tick();
        rst_n = 1'b1;

        // response arriving in IDLE after reset is ignored
        imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        tick();
        chk("idle_resp_ignored", {63'd0, d_valid}, 64'd0);
        chk("idle_resp_no_req", {63'd0, imem_req}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
